br_cmp_sched: RTL and testbench

- Branch reservation station and scheduler for the shared branch comparator in the execute stage.
- Holds up to DEPTH branch ops waiting on operands and snoops the CDB for missing operands.
- Each cycle, picks the oldest entry with both operands ready and drives it onto the single comparator (cmpop/a/b in, f back).
- Registers the taken/not-taken result with the op's ROB tag for the ROB/branch-resolve logic.

---
 rtl/br_cmp_sched.sv | 175 +++++++++++++++++
 tb/tb_br_cmp_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_cmp_sched.sv
// Branch reservation station feeding the shared branch comparator.
// Oldest-ready-first issue from a compacting queue, CDB snoop, registered result.
module br_cmp_sched #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [2:0]       alloc_cmpop,
   input  logic [31:0]      alloc_a_val,
   input  logic [31:0]      alloc_b_val,
   input  logic             alloc_a_rdy,
   input  logic             alloc_b_rdy,
   input  logic [TAG_W-1:0] alloc_a_tag,
   input  logic [TAG_W-1:0] alloc_b_tag,
   input  logic [TAG_W-1:0] alloc_rob_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   output logic [2:0]       cmp_cmpop,
   output logic [31:0]      cmp_a,
   output logic [31:0]      cmp_b,
   input  logic             cmp_f,
   output logic             res_valid,
   output logic [TAG_W-1:0] res_rob_tag,
   output logic             res_taken,
   input  logic             res_ready
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic             v;
      logic [2:0]       op;
      logic [31:0]      a_val;
      logic [31:0]      b_val;
      logic             a_rdy;
      logic             b_rdy;
      logic [TAG_W-1:0] a_tag;
      logic [TAG_W-1:0] b_tag;
      logic [TAG_W-1:0] rob;
   } ent_t;

   ent_t             ent_q [DEPTH];
   ent_t             ent_d [DEPTH];
   ent_t             snp   [DEPTH+1];
   ent_t             new_e;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [CW-1:0]    wr_idx;
   logic [IW-1:0]    sel;
   logic             has_cand;
   logic             issue;
   logic             alloc_fire;
   logic             res_valid_q;
   logic             res_valid_d;
   logic             res_taken_q;
   logic             res_taken_d;
   logic [TAG_W-1:0] res_tag_q;
   logic [TAG_W-1:0] res_tag_d;

   assign alloc_ready = (cnt_q != CW'(DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready;

   // Scan high to low so the lowest (oldest) ready slot wins.
   always_comb begin
      sel      = '0;
      has_cand = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ent_q[i].v && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
            sel      = IW'(i);
            has_cand = 1'b1;
         end
      end
   end

   assign issue     = has_cand && (!res_valid_q || res_ready);
   assign cmp_cmpop = issue ? ent_q[sel].op    : ent_q[0].op;
   assign cmp_a     = issue ? ent_q[sel].a_val : ent_q[0].a_val;
   assign cmp_b     = issue ? ent_q[sel].b_val : ent_q[0].b_val;

   always_comb begin
      new_e       = '0;
      new_e.v     = 1'b1;
      new_e.op    = alloc_cmpop;
      new_e.a_val = alloc_a_val;
      new_e.b_val = alloc_b_val;
      new_e.a_rdy = alloc_a_rdy;
      new_e.b_rdy = alloc_b_rdy;
      new_e.a_tag = alloc_a_tag;
      new_e.b_tag = alloc_b_tag;
      new_e.rob   = alloc_rob_tag;
      if (!alloc_a_rdy && cdb_valid && alloc_a_tag == cdb_tag) begin
         new_e.a_val = cdb_value;
         new_e.a_rdy = 1'b1;
      end
      if (!alloc_b_rdy && cdb_valid && alloc_b_tag == cdb_tag) begin
         new_e.b_val = cdb_value;
         new_e.b_rdy = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         snp[i] = ent_q[i];
         if (cdb_valid && ent_q[i].v && !ent_q[i].a_rdy
             && ent_q[i].a_tag == cdb_tag) begin
            snp[i].a_val = cdb_value;
            snp[i].a_rdy = 1'b1;
         end
         if (cdb_valid && ent_q[i].v && !ent_q[i].b_rdy
             && ent_q[i].b_tag == cdb_tag) begin
            snp[i].b_val = cdb_value;
            snp[i].b_rdy = 1'b1;
         end
      end
      snp[DEPTH] = '0;
      wr_idx     = cnt_q - CW'(issue);
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = (issue && i >= int'(sel)) ? snp[i+1] : snp[i];
         if (alloc_fire && wr_idx == CW'(i)) begin
            ent_d[i] = new_e;
         end
      end
      cnt_d = cnt_q + CW'(alloc_fire) - CW'(issue);
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = '0;
         end
         cnt_d = '0;
      end
   end

   always_comb begin
      res_valid_d = res_valid_q;
      res_taken_d = res_taken_q;
      res_tag_d   = res_tag_q;
      if (issue) begin
         res_valid_d = 1'b1;
         res_taken_d = cmp_f;
         res_tag_d   = ent_q[sel].rob;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
      if (flush) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_taken_q <= 1'b0;
         res_tag_q   <= '0;
      end else begin
         ent_q       <= ent_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_taken_q <= res_taken_d;
         res_tag_q   <= res_tag_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_taken   = res_taken_q;
   assign res_rob_tag = res_tag_q;

endmodule

// File: tb/tb_br_cmp_sched.sv
// Bench for br_cmp_sched: directed scenarios plus random traffic,
// checked against a queue-based model of the station.
module tb_br_cmp_sched;
   localparam int DEPTH = 4;
   localparam int TAG_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             alloc_valid;
   logic             alloc_ready;
   logic [2:0]       alloc_cmpop;
   logic [31:0]      alloc_a_val;
   logic [31:0]      alloc_b_val;
   logic             alloc_a_rdy;
   logic             alloc_b_rdy;
   logic [TAG_W-1:0] alloc_a_tag;
   logic [TAG_W-1:0] alloc_b_tag;
   logic [TAG_W-1:0] alloc_rob_tag;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_value;
   logic [2:0]       cmp_cmpop;
   logic [31:0]      cmp_a;
   logic [31:0]      cmp_b;
   logic             cmp_f;
   logic             res_valid;
   logic [TAG_W-1:0] res_rob_tag;
   logic             res_taken;
   logic             res_ready;

   always #5 clk = ~clk;

   br_cmp_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_cmpop(alloc_cmpop),
      .alloc_a_val(alloc_a_val), .alloc_b_val(alloc_b_val),
      .alloc_a_rdy(alloc_a_rdy), .alloc_b_rdy(alloc_b_rdy),
      .alloc_a_tag(alloc_a_tag), .alloc_b_tag(alloc_b_tag),
      .alloc_rob_tag(alloc_rob_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cmp_cmpop(cmp_cmpop), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_f(cmp_f),
      .res_valid(res_valid), .res_rob_tag(res_rob_tag),
      .res_taken(res_taken), .res_ready(res_ready)
   );

   function automatic logic br_eval(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
      case (op)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   always_comb cmp_f = br_eval(cmp_cmpop, cmp_a, cmp_b);

   typedef struct {
      logic [2:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      bit               ar;
      bit               br;
      logic [TAG_W-1:0] at;
      logic [TAG_W-1:0] bt;
      logic [TAG_W-1:0] rob;
   } ment_t;

   ment_t            q[$];
   bit               m_rv;
   bit               m_tk;
   logic [TAG_W-1:0] m_tag;
   int               n_chk = 0;
   int               n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      alloc_valid   = 1'b0;
      alloc_cmpop   = '0;
      alloc_a_val   = '0;
      alloc_b_val   = '0;
      alloc_a_rdy   = 1'b0;
      alloc_b_rdy   = 1'b0;
      alloc_a_tag   = '0;
      alloc_b_tag   = '0;
      alloc_rob_tag = '0;
      cdb_valid     = 1'b0;
      cdb_tag       = '0;
      cdb_value     = '0;
      flush         = 1'b0;
      res_ready     = 1'b1;
   endtask

   task automatic put(input logic [2:0] op,
                      input logic [31:0] a, input bit ar,
                      input logic [TAG_W-1:0] at,
                      input logic [31:0] b, input bit br,
                      input logic [TAG_W-1:0] bt,
                      input logic [TAG_W-1:0] rob);
      alloc_valid   = 1'b1;
      alloc_cmpop   = op;
      alloc_a_val   = a;
      alloc_a_rdy   = ar;
      alloc_a_tag   = at;
      alloc_b_val   = b;
      alloc_b_rdy   = br;
      alloc_b_tag   = bt;
      alloc_rob_tag = rob;
   endtask

   task automatic bcast(input logic [TAG_W-1:0] t, input logic [31:0] v);
      cdb_valid = 1'b1;
      cdb_tag   = t;
      cdb_value = v;
   endtask

   // One clock: check outputs against the model, advance the model.
   task automatic step();
      int    c;
      bit    iss;
      bit    do_alloc;
      ment_t e;
      #1;
      chk("alloc_ready", 32'(alloc_ready), 32'(q.size() != DEPTH));
      chk("res_valid", 32'(res_valid), 32'(m_rv));
      if (m_rv) begin
         chk("res_taken", 32'(res_taken), 32'(m_tk));
         chk("res_rob_tag", 32'(res_rob_tag), 32'(m_tag));
      end
      c = -1;
      for (int i = 0; i < q.size(); i++)
         if (c < 0 && q[i].ar && q[i].br) c = i;
      iss = (c >= 0) && (!m_rv || res_ready);
      if (iss) begin
         chk("cmp_cmpop", 32'(cmp_cmpop), 32'(q[c].op));
         chk("cmp_a", cmp_a, q[c].a);
         chk("cmp_b", cmp_b, q[c].b);
      end
      if (flush) begin
         q.delete();
         m_rv = 1'b0;
      end else begin
         do_alloc = alloc_valid && (q.size() < DEPTH);
         if (iss) begin
            m_rv  = 1'b1;
            m_tk  = br_eval(q[c].op, q[c].a, q[c].b);
            m_tag = q[c].rob;
         end else if (res_ready) begin
            m_rv = 1'b0;
         end
         if (cdb_valid) begin
            for (int i = 0; i < q.size(); i++) begin
               e = q[i];
               if (!e.ar && e.at == cdb_tag) begin
                  e.a  = cdb_value;
                  e.ar = 1'b1;
               end
               if (!e.br && e.bt == cdb_tag) begin
                  e.b  = cdb_value;
                  e.br = 1'b1;
               end
               q[i] = e;
            end
         end
         if (iss) q.delete(c);
         if (do_alloc) begin
            e.op  = alloc_cmpop;
            e.a   = alloc_a_val;
            e.b   = alloc_b_val;
            e.ar  = alloc_a_rdy;
            e.br  = alloc_b_rdy;
            e.at  = alloc_a_tag;
            e.bt  = alloc_b_tag;
            e.rob = alloc_rob_tag;
            if (!e.ar && cdb_valid && e.at == cdb_tag) begin
               e.a  = cdb_value;
               e.ar = 1'b1;
            end
            if (!e.br && cdb_valid && e.bt == cdb_tag) begin
               e.b  = cdb_value;
               e.br = 1'b1;
            end
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_res_taken", 32'(res_taken), 32'd0);
      chk("rst_res_rob_tag", 32'(res_rob_tag), 32'd0);
      chk("rst_cmp_a", cmp_a, 32'd0);
      chk("rst_cmp_cmpop", 32'(cmp_cmpop), 32'd0);
      q.delete();
      m_rv  = 1'b0;
      m_tk  = 1'b0;
      m_tag = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'hFFFF_FFFF;
         default: return 32'($urandom_range(0, 3));
      endcase
   endfunction

   function automatic logic [2:0] rop();
      logic [2:0] ops [6];
      ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      return ops[$urandom_range(0, 5)];
   endfunction

   initial begin
      idle();
      rst = 1'b0;
      @(negedge clk);
      do_reset();

      // ready-at-dispatch beq
      idle(); put(3'b000, 32'd5, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 3'd2); step();
      idle(); step();
      chk("beq_valid", 32'(res_valid), 32'd1);
      chk("beq_taken", 32'(res_taken), 32'd1);
      chk("beq_tag", 32'(res_rob_tag), 32'd2);

      // signed vs unsigned less-than
      idle(); put(3'b100, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd3); step();
      idle(); put(3'b110, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd4); step();
      chk("blt_taken", 32'(res_taken), 32'd1);
      chk("blt_tag", 32'(res_rob_tag), 32'd3);
      idle(); step();
      chk("bltu_taken", 32'(res_taken), 32'd0);
      chk("bltu_tag", 32'(res_rob_tag), 32'd4);
      idle(); step();

      // younger ready op overtakes older waiting op
      idle(); put(3'b000, 32'd0, 1'b0, 3'd6, 32'd7, 1'b1, 3'd0, 3'd1); step();
      idle(); put(3'b001, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 3'd2); step();
      idle(); bcast(3'd6, 32'd7); step();
      chk("order_first_tag", 32'(res_rob_tag), 32'd2);
      idle(); step();
      chk("order_second_tag", 32'(res_rob_tag), 32'd1);
      chk("order_second_taken", 32'(res_taken), 32'd1);
      idle(); step();

      // CDB bypass at allocation
      idle(); put(3'b000, 32'd0, 1'b0, 3'd4, 32'd9, 1'b1, 3'd0, 3'd5);
      bcast(3'd4, 32'd9); step();
      idle(); step();
      chk("bypass_valid", 32'(res_valid), 32'd1);
      chk("bypass_taken", 32'(res_taken), 32'd1);
      chk("bypass_tag", 32'(res_rob_tag), 32'd5);
      idle(); step();

      // fill, overflow attempt, backpressure, drain
      for (int k = 0; k < DEPTH; k++) begin
         idle();
         put(3'b101, 32'd0, 1'b0, TAG_W'(k + 1), 32'(k * 5), 1'b1, 3'd0, TAG_W'(k));
         step();
      end
      chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
      idle(); put(3'b000, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd7); step();
      for (int k = 0; k < DEPTH; k++) begin
         idle(); res_ready = 1'b0; bcast(TAG_W'(k + 1), 32'd10); step();
      end
      idle(); res_ready = 1'b0; step();
      idle(); res_ready = 1'b0; step();
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      chk("bp_hold_tag", 32'(res_rob_tag), 32'd0);
      for (int k = 0; k < DEPTH + 2; k++) begin
         idle(); step();
      end

      // flush kills entries, result and same-cycle alloc
      idle(); res_ready = 1'b0;
      put(3'b000, 32'd0, 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 3'd1); step();
      idle(); res_ready = 1'b0;
      put(3'b000, 32'd0, 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 3'd2); step();
      idle(); res_ready = 1'b0;
      put(3'b000, 32'd3, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 3'd3); step();
      idle(); res_ready = 1'b0; step();
      chk("pre_flush_valid", 32'(res_valid), 32'd1);
      idle(); res_ready = 1'b0; flush = 1'b1;
      put(3'b000, 32'd1, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd4); step();
      chk("flush_res_valid", 32'(res_valid), 32'd0);
      chk("flush_alloc_ready", 32'(alloc_ready), 32'd1);
      idle(); bcast(3'd7, 32'd0); step();
      idle(); step();
      chk("flush_no_issue", 32'(res_valid), 32'd0);

      // reset mid-stream with three entries held
      for (int k = 0; k < 3; k++) begin
         idle(); put(3'b000, 32'd0, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, TAG_W'(k)); step();
      end
      idle(); put(3'b001, 32'd0, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 3'd6);
      do_reset();
      idle(); bcast(3'd5, 32'd0); step();
      idle(); step();
      idle(); step();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         if ($urandom_range(0, 1) == 1)
            put(rop(), rval(), 1'($urandom_range(0, 1)), TAG_W'($urandom),
                rval(), 1'($urandom_range(0, 1)), TAG_W'($urandom),
                TAG_W'($urandom));
         if ($urandom_range(0, 9) < 4) bcast(TAG_W'($urandom), rval());
         res_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
